// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings shared by the ALU and its users
package alu_pkg;
  localparam int ALU_SEL_W = 3;
  localparam logic [ALU_SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_SEL_W-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_SEL_W-1:0] OP_AND = 3'b010;
  localparam logic [ALU_SEL_W-1:0] OP_OR  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] OP_XOR = 3'b100;
  localparam logic [ALU_SEL_W-1:0] OP_NOT = 3'b101;
  localparam logic [ALU_SEL_W-1:0] OP_SHL = 3'b110;
  localparam logic [ALU_SEL_W-1:0] OP_SHR = 3'b111;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: single carry chain adder/subtractor, carry is borrow when subtracting
module alu_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0] r;
  assign r = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
  assign sum = r[WIDTH-1:0];
  assign carry = r[WIDTH] ^ sub;
endmodule

// File: rtl/alu.sv
// alu: registered arithmetic/logic unit with one-cycle latency
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [ALU_SEL_W-1:0] ALU_Sel,
  output logic [WIDTH-1:0]     ALU_Out,
  output logic                 CarryOut
);
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] res;
  logic             c;
  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(A),
    .b(B),
    .sub(ALU_Sel == OP_SUB),
    .sum(sum),
    .carry(carry)
  );
  always_comb begin
    res = '0;
    c = 1'b0;
    case (ALU_Sel)
      OP_ADD, OP_SUB: {c, res} = {carry, sum};
      OP_AND:         res = A & B;
      OP_OR:          res = A | B;
      OP_XOR:         res = A ^ B;
      OP_NOT:         res = ~A;
      OP_SHL:         {c, res} = {A, 1'b0};
      OP_SHR:         {res, c} = {1'b0, A};
      default: begin
        res = '0;
        c = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_Out <= '0;
      CarryOut <= 1'b0;
    end else begin
      ALU_Out <= res;
      CarryOut <= c;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for 4- and 8-bit ALU instances
module tb_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, o4;
  logic [2:0] s4 = '0, s8 = '0;
  logic [7:0] a8 = '0, b8 = '0, o8;
  logic       c4, c8;
  logic [4:0] q4[$];
  string      t4[$];
  logic [8:0] q8[$];
  int         vectors = 0;
  int         miscompares = 0;
  always #5 clk = ~clk;
  alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .ALU_Sel(s4), .ALU_Out(o4), .CarryOut(c4)
  );
  alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .ALU_Sel(s8), .ALU_Out(o8), .CarryOut(c8)
  );
  function automatic logic [8:0] model(input int w, input int a, input int b, input int s);
    int m = (1 << w) - 1;
    int r = 0;
    int c = 0;
    case (s)
      0: begin r = a + b; c = (r >> w) & 1; end
      1: begin r = a - b; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = a << 1; c = (a >> (w - 1)) & 1; end
      default: begin r = a >> 1; c = a & 1; end
    endcase
    r = r & m;
    return 9'((c << w) | r);
  endfunction
  task automatic check();
    logic [4:0] e4;
    logic [8:0] e8;
    string tag;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      tag = t4.pop_front();
      vectors++;
      assert ({c4, o4} === e4) else begin
        miscompares++;
        $error("FAIL %s: got %b/%b expected %b/%b", tag, o4, c4, e4[3:0], e4[4]);
      end
    end
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      vectors++;
      assert ({c8, o8} === e8) else begin
        miscompares++;
        $error("FAIL w8: got %h/%b expected %h/%b", o8, c8, e8[7:0], e8[8]);
      end
    end
  endtask
  task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] s, input logic [4:0] e, input string tag);
    logic [8:0] m8;
    @(posedge clk);
    #1;
    check();
    rst = r;
    a4 = a;
    b4 = b;
    s4 = s;
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
    s8 = 3'($urandom_range(0, 7));
    m8 = model(8, int'(a8), int'(b8), int'(s8));
    q4.push_back(r ? 5'b0 : e);
    t4.push_back(tag);
    q8.push_back(r ? 9'b0 : m8);
  endtask
  initial begin
    logic [4:0] e;
    logic [3:0] ra, rb;
    logic [2:0] rs;
    a4 = 4'hF; b4 = 4'hF; s4 = 3'b000;
    q4.push_back(5'b0); t4.push_back("rst0"); q8.push_back(9'b0);
    drive(1, 4'hF, 4'hF, 3'b000, 5'b0, "rst1");
    drive(0, 4'hF, 4'hF, 3'b000, 5'b1_1110, "post_rst");
    drive(0, 4'b1011, 4'b0101, 3'b000, 5'b1_0000, "add");
    drive(0, 4'b1011, 4'b0101, 3'b001, 5'b0_0110, "sub");
    drive(0, 4'b1011, 4'b0101, 3'b010, 5'b0_0001, "and");
    drive(0, 4'b1011, 4'b0101, 3'b011, 5'b0_1111, "or");
    drive(0, 4'b1011, 4'b0101, 3'b100, 5'b0_1110, "xor");
    drive(0, 4'b1011, 4'b0101, 3'b101, 5'b0_0100, "not");
    drive(0, 4'b1011, 4'b0101, 3'b110, 5'b1_0110, "shl");
    drive(0, 4'b1011, 4'b0101, 3'b111, 5'b1_0101, "shr");
    drive(0, 4'b0000, 4'b0001, 3'b001, 5'b1_1111, "sub_borrow");
    drive(0, 4'b0111, 4'b0111, 3'b001, 5'b0_0000, "sub_eq");
    drive(0, 4'b0111, 4'b0001, 3'b000, 5'b0_1000, "add_msb");
    drive(0, 4'b1111, 4'b0001, 3'b000, 5'b1_0000, "add_wrap");
    drive(0, 4'd3, 4'd4, 3'b000, 5'b0_0111, "pipe_add");
    drive(0, 4'hC, 4'hA, 3'b010, 5'b0_1000, "pipe_and");
    drive(0, 4'b1001, 4'b0000, 3'b111, 5'b1_0100, "pipe_shr");
    drive(0, 4'b1011, 4'b0101, 3'b000, 5'b1_0000, "sweep2_add");
    drive(0, 4'b1011, 4'b0101, 3'b001, 5'b0_0110, "sweep2_sub");
    drive(1, 4'b1011, 4'b0101, 3'b010, 5'b0, "mid_rst");
    drive(0, 4'b1011, 4'b0101, 3'b011, 5'b0_1111, "resume_or");
    drive(0, 4'b1011, 4'b0101, 3'b110, 5'b1_0110, "resume_shl");
    for (int i = 0; i < 1000; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      e = 5'(model(4, int'(ra), int'(rb), int'(rs)));
      drive(0, ra, rb, rs, e, "rnd");
    end
    @(posedge clk);
    #1;
    check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
